mdr_unit: RTL and testbench
===========================

Name: mdr_unit

Overview:
- Memory Data Register stage for the 32-bit bus datapath.
- Consumes the bus multiplexer output (`bus_contents`) and supplies its registered value back to the bus multiplexer as one of its data inputs.
- Owns the memory read/write handshake with a req/ack protocol and a bounded wait timeout.
- Replaces the bare MDR register so that memory stalls are visible to the control unit through `busy` and `done`.

Parameters:
- DATA_W, 32, width of the bus, `mdr_q` and memory data.
- TIMEOUT, 16, maximum cycles spent in a wait state before abort (legal range 2..255).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset.
- bus_contents  in  DATA_W  current bus value from the bus multiplexer.
- mdr_in  in  1  load strobe; one cycle wide, accepted only in IDLE.
- read  in  1  load source with `mdr_in`: 0 = bus, 1 = memory read.
- mem_write  in  1  start a memory write of the current `mdr_q`; accepted only in IDLE.
- mem_rdata  in  DATA_W  memory read data, valid when `mem_ack`=1 in RD_WAIT.
- mem_ack  in  1  memory completion acknowledge.
- mdr_q  out  DATA_W  MDR contents, routed to the bus multiplexer.
- mem_rd_req  out  1  read request level.
- mem_wr_req  out  1  write request level.
- mem_wdata  out  DATA_W  write data, held stable for the whole write.
- busy  out  1  high in RD_WAIT and WR_WAIT.
- done  out  1  one-cycle pulse on successful memory completion.
- cmd_err  out  1  one-cycle pulse when a command is dropped.
- timeout_err  out  1  sticky flag; cleared only by `clr`.

Behaviour:
- Reset: `clr`=1 at an edge forces state IDLE and sets every output to 0: `mdr_q`, `mem_wdata`, `mem_rd_req`, `mem_wr_req`, `busy`, `done`, `cmd_err`, `timeout_err`. The wait counter also clears to 0.
- Reset mid-transaction: `clr` abandons the transaction. Requests read 0 from the next cycle, and a late `mem_ack` after that is ignored.
- States are IDLE, RD_WAIT and WR_WAIT. All outputs are registered, with no combinational input-to-output paths.
- IDLE, `mdr_in`=1 and `read`=0: `mdr_q` takes `bus_contents` at the same edge (1-cycle latency). State remains IDLE.
- IDLE, `mdr_in`=1 and `read`=1: at that edge `mem_rd_req` goes to 1, the counter clears and state becomes RD_WAIT.
- IDLE, `mem_write`=1: at that edge `mem_wdata` takes `mdr_q`, `mem_wr_req` goes to 1, the counter clears and state becomes WR_WAIT.
- Simultaneous bus load and `mem_write` (`mdr_in`=1, `read`=0, `mem_write`=1): both are performed at the same edge. `mem_wdata` gets the OLD `mdr_q` and `mdr_q` gets `bus_contents`.
- Simultaneous memory read and `mem_write` (`mdr_in`=1, `read`=1, `mem_write`=1): the write wins and the read is dropped. `cmd_err` pulses for 1 cycle.
- RD_WAIT: `mem_rd_req` holds at 1 and `busy`=1. On each edge with `mem_ack`=1:
  - `mdr_q` takes `mem_rdata` and `mem_rd_req` goes to 0;
  - `done` pulses for the next cycle;
  - state becomes IDLE.
- WR_WAIT: `mem_wr_req` holds at 1 and `mem_wdata` is frozen. On `mem_ack`, `mem_wr_req` goes to 0, `done` pulses and state becomes IDLE. `mdr_q` is unchanged.
- Timeout: in either wait state the counter increments on every edge without `mem_ack`. At an edge with the counter = TIMEOUT-1 and `mem_ack`=0:
  - the request drops and `timeout_err` sets to 1;
  - `done` stays 0;
  - `mdr_q` is unchanged and state becomes IDLE.
- Ack wins at the timeout boundary: `mem_ack`=1 on the same edge as counter = TIMEOUT-1 counts as success and does not set `timeout_err`.
- Commands while busy: `mdr_in` or `mem_write` asserted while `busy`=1 are dropped. `cmd_err` pulses for 1 cycle per offending cycle. The in-flight transaction is unaffected.
- `mem_ack` received in IDLE is ignored with no side effects.
- Back-to-back operation: a new command is accepted in the first cycle after `done`, so there is no dead cycle.

Test Plan:
- Bus load: `clr` pulse, then `bus_contents`=0xDEADBEEF with `mdr_in`=1, `read`=0 for 1 cycle → `mdr_q`=0xDEADBEEF one edge later; `busy`=0 and `done`=0 throughout.
- Memory read: `mdr_in`=1, `read`=1, `mem_ack` raised 3 cycles after `mem_rd_req` with `mem_rdata`=0x12345678 → `mdr_q`=0x12345678. `mem_rd_req` drops at the ack edge, `done` is a single 1-cycle pulse, and `busy` is high for exactly 4 cycles.
- Write with simultaneous load: `mdr_q`=0xAAAA0000, then `mem_write`=1 together with a bus load of 0x5555FFFF → `mem_wdata`=0xAAAA0000 held for the whole of WR_WAIT and `mdr_q`=0x5555FFFF. After `mem_ack`, `done` pulses and `mem_wr_req` reads 0.
- Timeout, TIMEOUT=16:
  - read issued with no ack → at the 16th edge the request drops, `timeout_err`=1, `mdr_q` is unchanged and `done`=0;
  - `timeout_err` stays 1 through a following successful read and clears only after `clr`;
  - separately, an ack on exactly the 16th edge → success with `timeout_err`=0.
- Busy rejection: `mdr_in`=1 pulsed during RD_WAIT → `cmd_err` pulses for 1 cycle and the read completes with `mem_rdata`, not the bus value. Read and write issued together → WR_WAIT is entered, `mem_rd_req`=0 and `cmd_err` pulses.
- Reset mid-read: `clr`=1 two cycles into RD_WAIT → the next cycle shows all outputs 0 and state IDLE. A `mem_ack` with 0xFFFFFFFF one cycle later leaves `mdr_q`=0 and `done`=0.

Source files
------------

// File: rtl/mdr_unit.sv
// Memory data register with a req/ack memory handshake and a bounded wait; every output is registered.
// A load lands in 1 cycle, memory ops finish on ack or time out; commands arriving while busy are dropped and flagged.
module mdr_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_contents,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr_q,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mdr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              tout_q, tout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdr_d     = mdr_q;
    wdata_d   = wdata_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    done_d    = 1'b0;
    cmd_err_d = 1'b0;
    tout_d    = tout_q;

    case (state_q)
      IDLE: begin
        if (mem_write) begin
          // Write captures the pre-load MDR; a same-cycle bus load still lands.
          wdata_d  = mdr_q;
          wr_req_d = 1'b1;
          cnt_d    = 8'd0;
          state_d  = WR_WAIT;
          if (mdr_in && !read) mdr_d = bus_contents;
          if (mdr_in && read)  cmd_err_d = 1'b1;
        end else if (mdr_in) begin
          if (read) begin
            rd_req_d = 1'b1;
            cnt_d    = 8'd0;
            state_d  = RD_WAIT;
          end else begin
            mdr_d = bus_contents;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mdr_in || mem_write) cmd_err_d = 1'b1;
        // Ack takes priority over an expiring counter on the same edge.
        if (mem_ack) begin
          if (state_q == RD_WAIT) mdr_d = mem_rdata;
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          tout_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      mdr_q     <= '0;
      wdata_q   <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mdr_q     <= mdr_d;
      wdata_q   <= wdata_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
      tout_q    <= tout_d;
    end
  end

  assign mem_rd_req  = rd_req_q;
  assign mem_wr_req  = wr_req_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_err     = cmd_err_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Bench for mdr_unit: directed vector table, hand-written corner sequences, random traffic vs a reference model.
module tb_mdr_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        clr, mdr_in, read, mem_write, mem_ack;
  logic [31:0] bus_contents, mem_rdata;
  logic [31:0] mdr_q, mem_wdata;
  logic        mem_rd_req, mem_wr_req, busy, done, cmd_err, timeout_err;

  int checks = 0;
  int failures = 0;

  mdr_unit #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .bus_contents(bus_contents), .mdr_in(mdr_in),
    .read(read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mdr_q(mdr_q), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .cmd_err(cmd_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: the transaction in flight and how many edges it has waited.
  int          m_op;      // 0 none, 1 read, 2 write
  int          m_waited;
  logic [31:0] m_mdr, m_wdata;
  logic        m_done, m_cerr, m_tout;

  function automatic void model_edge();
    if (clr) begin
      m_op = 0; m_waited = 0; m_mdr = 0; m_wdata = 0;
      m_done = 0; m_cerr = 0; m_tout = 0;
      return;
    end
    m_done = 0;
    m_cerr = 0;
    if (m_op == 0) begin
      if (mem_write) begin
        m_wdata = m_mdr;
        if (mdr_in && !read) m_mdr = bus_contents;
        if (mdr_in && read) m_cerr = 1;
        m_op = 2; m_waited = 0;
      end else if (mdr_in) begin
        if (read) begin m_op = 1; m_waited = 0; end
        else m_mdr = bus_contents;
      end
    end else begin
      if (mdr_in || mem_write) m_cerr = 1;
      if (mem_ack) begin
        if (m_op == 1) m_mdr = mem_rdata;
        m_done = 1;
        m_op = 0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin m_tout = 1; m_op = 0; end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".mdr"},   mdr_q,       m_mdr);
    chk({tag, ".wdata"}, mem_wdata,   m_wdata);
    chk({tag, ".rdreq"}, 32'(mem_rd_req), 32'(m_op == 1));
    chk({tag, ".wrreq"}, 32'(mem_wr_req), 32'(m_op == 2));
    chk({tag, ".busy"},  32'(busy),   32'(m_op != 0));
    chk({tag, ".done"},  32'(done),   32'(m_done));
    chk({tag, ".cerr"},  32'(cmd_err), 32'(m_cerr));
    chk({tag, ".tout"},  32'(timeout_err), 32'(m_tout));
  endtask

  task automatic drive(input logic c, input logic mi, input logic rd, input logic wr,
                       input logic ak, input logic [31:0] b, input logic [31:0] rdat);
    clr = c; mdr_in = mi; read = rd; mem_write = wr; mem_ack = ak;
    bus_contents = b; mem_rdata = rdat;
  endtask

  typedef struct {
    logic        c, mi, rd, wr, ak;
    logic [31:0] bus, rdat;
    logic [31:0] e_mdr, e_wdata;
    logic        e_rq, e_wq, e_by, e_dn, e_ce, e_to;
  } vec_t;

  function automatic vec_t mk(input logic c, mi, rd, wr, ak, input logic [31:0] bus, rdat,
                              input logic [31:0] e_mdr, e_wdata,
                              input logic e_rq, e_wq, e_by, e_dn, e_ce, e_to);
    vec_t v;
    v.c = c; v.mi = mi; v.rd = rd; v.wr = wr; v.ak = ak; v.bus = bus; v.rdat = rdat;
    v.e_mdr = e_mdr; v.e_wdata = e_wdata; v.e_rq = e_rq; v.e_wq = e_wq;
    v.e_by = e_by; v.e_dn = e_dn; v.e_ce = e_ce; v.e_to = e_to;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1,0,0,0,0, 0, 0,                    0, 0, 0,0,0,0,0,0);
    tbl[1]  = mk(0,1,0,0,0, 32'hDEADBEEF, 0,         32'hDEADBEEF, 0, 0,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0, 0, 0,                    32'hDEADBEEF, 0, 0,0,0,0,0,0);
    tbl[3]  = mk(0,1,1,0,0, 0, 0,                    32'hDEADBEEF, 0, 1,0,1,0,0,0);
    tbl[4]  = mk(0,0,0,0,0, 0, 0,                    32'hDEADBEEF, 0, 1,0,1,0,0,0);
    tbl[5]  = mk(0,0,0,0,0, 0, 0,                    32'hDEADBEEF, 0, 1,0,1,0,0,0);
    tbl[6]  = mk(0,0,0,0,0, 0, 0,                    32'hDEADBEEF, 0, 1,0,1,0,0,0);
    tbl[7]  = mk(0,0,0,0,1, 0, 32'h12345678,         32'h12345678, 0, 0,0,0,1,0,0);
    tbl[8]  = mk(0,0,0,0,0, 0, 0,                    32'h12345678, 0, 0,0,0,0,0,0);
    tbl[9]  = mk(0,1,0,0,0, 32'hAAAA0000, 0,         32'hAAAA0000, 0, 0,0,0,0,0,0);
    tbl[10] = mk(0,1,0,1,0, 32'h5555FFFF, 0,         32'h5555FFFF, 32'hAAAA0000, 0,1,1,0,0,0);
    tbl[11] = mk(0,0,0,0,0, 0, 0,                    32'h5555FFFF, 32'hAAAA0000, 0,1,1,0,0,0);
    tbl[12] = mk(0,1,0,0,0, 32'h11111111, 0,         32'h5555FFFF, 32'hAAAA0000, 0,1,1,0,1,0);
    tbl[13] = mk(0,0,0,0,1, 0, 0,                    32'h5555FFFF, 32'hAAAA0000, 0,0,0,1,0,0);
    tbl[14] = mk(0,1,1,1,0, 0, 0,                    32'h5555FFFF, 32'h5555FFFF, 0,1,1,0,1,0);
    tbl[15] = mk(0,0,0,0,1, 0, 0,                    32'h5555FFFF, 32'h5555FFFF, 0,0,0,1,0,0);
    tbl[16] = mk(0,1,1,0,0, 0, 0,                    32'h5555FFFF, 32'h5555FFFF, 1,0,1,0,0,0);
    tbl[17] = mk(0,1,0,0,0, 32'hCAFEBABE, 0,         32'h5555FFFF, 32'h5555FFFF, 1,0,1,0,1,0);
    tbl[18] = mk(0,0,0,0,1, 0, 32'h0BADF00D,         32'h0BADF00D, 32'h5555FFFF, 0,0,0,1,0,0);
    tbl[19] = mk(0,0,0,0,1, 0, 32'hFFFFFFFF,         32'h0BADF00D, 32'h5555FFFF, 0,0,0,0,0,0);

    drive(0,0,0,0,0,0,0);
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].c, tbl[i].mi, tbl[i].rd, tbl[i].wr, tbl[i].ak, tbl[i].bus, tbl[i].rdat);
      step(t);
      chk({t, ".tbl_mdr"},   mdr_q,              tbl[i].e_mdr);
      chk({t, ".tbl_wdata"}, mem_wdata,          tbl[i].e_wdata);
      chk({t, ".tbl_rq"},    32'(mem_rd_req),    32'(tbl[i].e_rq));
      chk({t, ".tbl_wq"},    32'(mem_wr_req),    32'(tbl[i].e_wq));
      chk({t, ".tbl_busy"},  32'(busy),          32'(tbl[i].e_by));
      chk({t, ".tbl_done"},  32'(done),          32'(tbl[i].e_dn));
      chk({t, ".tbl_cerr"},  32'(cmd_err),       32'(tbl[i].e_ce));
      chk({t, ".tbl_tout"},  32'(timeout_err),   32'(tbl[i].e_to));
    end

    // Timeout with no ack: request held for 15 edges, dropped on the 16th.
    drive(1,0,0,0,0,0,0); step("to_clr");
    drive(0,1,0,0,0,32'h13579BDF,0); step("to_load");
    drive(0,1,1,0,0,0,0); step("to_cmd");
    drive(0,0,0,0,0,0,0);
    for (int k = 1; k < TO; k++) begin
      step("to_wait");
      chk($sformatf("to_hold%0d", k), 32'(mem_rd_req), 32'd1);
    end
    step("to_expire");
    chk("to_rq_drop", 32'(mem_rd_req), 32'd0);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    chk("to_no_done", 32'(done), 32'd0);
    chk("to_mdr_kept", mdr_q, 32'h13579BDF);
    // Sticky through a successful read, cleared by reset.
    drive(0,1,1,0,0,0,0); step("to_rd2");
    drive(0,0,0,0,1,0,32'h600DF00D); step("to_rd2_ack");
    chk("to_sticky", 32'(timeout_err), 32'd1);
    chk("to_rd2_mdr", mdr_q, 32'h600DF00D);
    drive(1,0,0,0,0,0,0); step("to_clr2");
    chk("to_cleared", 32'(timeout_err), 32'd0);

    // Ack on exactly the 16th edge counts as success.
    drive(0,1,1,0,0,0,0); step("ab_cmd");
    drive(0,0,0,0,0,0,0);
    for (int k = 1; k < TO; k++) step("ab_wait");
    drive(0,0,0,0,1,0,32'h2468ACE0); step("ab_ack");
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_no_tout", 32'(timeout_err), 32'd0);
    chk("ab_mdr", mdr_q, 32'h2468ACE0);

    // Reset two cycles into a read; a late ack is ignored.
    drive(0,1,1,0,0,0,0); step("rm_cmd");
    drive(0,0,0,0,0,0,0); step("rm_w1"); step("rm_w2");
    drive(1,0,0,0,0,0,0); step("rm_clr");
    chk("rm_rq", 32'(mem_rd_req), 32'd0);
    chk("rm_mdr", mdr_q, 32'd0);
    drive(0,0,0,0,1,0,32'hFFFFFFFF); step("rm_late_ack");
    chk("rm_late_mdr", mdr_q, 32'd0);
    chk("rm_late_done", 32'(done), 32'd0);

    // Random traffic against the reference model, with varied ack density.
    begin
      int ack_pct;
      ack_pct = 30;
      for (int n = 0; n < 3000; n++) begin
        if (n % 250 == 0) ack_pct = (n / 250) % 3 == 0 ? 5 : ((n / 250) % 3 == 1 ? 35 : 80);
        drive($urandom_range(0, 149) == 0,
              $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)),
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 99) < ack_pct,
              $urandom, $urandom);
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
